pixel_frame_ctrl: RTL and testbench
===================================

Name: pixel_frame_ctrl

Overview:
Frame sequencer for the pixel array. It drives the global pixel phases (erase, expose, convert, read) and the ADC ramp code shared by all pixels. It also schedules row-by-row readout onto the shared 32-bit databus. It sits between the chip-level control and the analog pixel array / bus mux.

Parameters:
C_ERASE, 5, erase phase length in clk cycles (>=1)
C_EXPOSE, 255, exposure phase length in clk cycles (>=1)
ADC_W, 8, ADC code width; convert phase lasts exactly 2**ADC_W cycles
C_READ, 5, cycles the read strobe is held per row (>=2)
NUM_ROWS, 2, number of pixel rows read sequentially onto the bus

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous reset, active-low
start  in  1  level/pulse; begins a frame when sampled high in IDLE
cont_en  in  1  1 = loop to next frame after READ; 0 = return to IDLE
erase  out  1  global pixel erase
expose  out  1  global pixel expose
convert  out  1  global convert enable (ramp running)
adc_code  out  ADC_W  ramp/counter code broadcast to pixel latches
read  out  1  read strobe for the row selected by row_sel
row_sel  out  NUM_ROWS  one-hot row select; all-zero outside READ
data_valid  out  1  one-cycle pulse: databus holds a valid row word
frame_done  out  1  one-cycle pulse on the last READ cycle of a frame
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: clk edge with reset==0 -> state IDLE; all outputs 0; phase counter, row index and adc_code = 0. Applies mid-frame (abort, no frame_done).
- All outputs registered; each is a pure function of the registered state/counters.
- States: IDLE, ERASE, EXPOSE, CONVERT, READ.
- IDLE: start sampled high at edge k -> ERASE is visible from cycle k+1. start is ignored in every other state.
- ERASE: erase=1 for exactly C_ERASE cycles, then EXPOSE.
- EXPOSE: expose=1 for exactly C_EXPOSE cycles, then CONVERT.
- CONVERT: convert=1 for 2**ADC_W cycles. adc_code=0 in the first cycle and increments by 1 each cycle, reaching 2**ADC_W-1 in the last. It does not wrap inside the phase. adc_code resets to 0 on exit and holds 0 outside CONVERT.
- READ: rows 0..NUM_ROWS-1 in order. Each row gets row_sel=one-hot(row) and read=1 for C_READ cycles. data_valid=1 on the last cycle of each row. frame_done=1 on the last cycle of the last row, coincident with that row's data_valid.
- After READ: cont_en==1 (sampled on the last READ cycle) -> ERASE next cycle with no gap; otherwise IDLE.
- Phase outputs are mutually exclusive; exactly one of erase/expose/convert/read is high whenever busy=1.
- Phase counter width = clog2(max(C_ERASE, C_EXPOSE, 2**ADC_W, C_READ)) + 1. It is a down-counter loaded on phase entry, with the transition at count==1.
- Row index width = clog2(NUM_ROWS); NUM_ROWS=1 must work (row_sel=1'b1).
- Frame length = C_ERASE + C_EXPOSE + 2**ADC_W + NUM_ROWS*C_READ cycles. With defaults this is 526.

Decomposition:
- Shared package pixel_pkg holds:
  - the state enum (IDLE, ERASE, EXPOSE, CONVERT, READ);
  - default timing constants C_ERASE, C_EXPOSE, C_READ, ADC_W, NUM_ROWS;
  - a clog2 helper.
- One natural sub-module: pixel_adc_ramp. It is an ADC_W counter with enable and clear, driven by the FSM. The FSM, phase counter and row scheduler stay in pixel_frame_ctrl.

Test Plan:
- Defaults, reset released, start=1 in cycle 0 only, cont_en=0 -> the frame runs as follows:
  - erase high cycles 1-5;
  - expose high cycles 6-260;
  - convert high cycles 261-516, with adc_code=0 at 261, 127 at 388 and 255 at 516;
  - read with row_sel=01 in cycles 517-521, then row_sel=10 in cycles 522-526;
  - data_valid in cycles 521 and 526, frame_done in cycle 526;
  - busy=0 and all outputs 0 from cycle 527.
- cont_en=1 held, one start -> erase rises again in cycle 527 (no idle gap) and the second frame_done occurs in cycle 1052.
- start held high through the whole frame with cont_en=0 -> start has no effect mid-frame; a new erase begins in cycle 528 (start sampled in IDLE at 527).
- reset=0 for one cycle during CONVERT (at cycle 300) -> next cycle all outputs 0, adc_code=0, IDLE, no frame_done. A later start gives a full, correct frame.
- Parameter override C_ERASE=1, C_EXPOSE=1, ADC_W=2, C_READ=2, NUM_ROWS=1 -> erase 1, expose 2, convert 3-6 with adc_code 0,1,2,3, read 7-8, data_valid and frame_done both in cycle 8.
- Every cycle of a default run, via assertions:
  - at most one phase output is high;
  - row_sel is one-hot exactly when read=1;
  - adc_code!=0 only while convert=1.

Source files
------------

// File: rtl/pixel_pkg.sv
// ---------------------------------------------------------------------------
// pixel_pkg : shared state encoding, default frame timing and helpers
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pixel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ    = 3'd4
  } state_t;

  localparam int C_ERASE  = 5;
  localparam int C_EXPOSE = 255;
  localparam int ADC_W    = 8;
  localparam int C_READ   = 5;
  localparam int NUM_ROWS = 2;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_adc_ramp.sv
// ---------------------------------------------------------------------------
// pixel_adc_ramp : ADC ramp code counter with clear (priority) and enable
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pixel_adc_ramp #(
  parameter int ADC_W = pixel_pkg::ADC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [ADC_W-1:0] code
);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      code <= '0;
    end else if (en) begin
      code <= code + ADC_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pixel_frame_ctrl.sv
// ---------------------------------------------------------------------------
// pixel_frame_ctrl : global pixel phase sequencer and row readout scheduler
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pixel_frame_ctrl #(
  parameter int C_ERASE  = pixel_pkg::C_ERASE,
  parameter int C_EXPOSE = pixel_pkg::C_EXPOSE,
  parameter int ADC_W    = pixel_pkg::ADC_W,
  parameter int C_READ   = pixel_pkg::C_READ,
  parameter int NUM_ROWS = pixel_pkg::NUM_ROWS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                cont_en,
  output logic                erase,
  output logic                expose,
  output logic                convert,
  output logic [ADC_W-1:0]    adc_code,
  output logic                read,
  output logic [NUM_ROWS-1:0] row_sel,
  output logic                data_valid,
  output logic                frame_done,
  output logic                busy
);

  import pixel_pkg::*;

  localparam int C_CONV  = 2 ** ADC_W;
  localparam int MAX_A   = (C_ERASE > C_EXPOSE) ? C_ERASE : C_EXPOSE;
  localparam int MAX_B   = (C_CONV > C_READ) ? C_CONV : C_READ;
  localparam int MAX_ALL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = clog2(MAX_ALL) + 1;
  // A single-row array still needs a 1-bit index to keep the vectors legal.
  localparam int ROW_W   = (NUM_ROWS > 1) ? clog2(NUM_ROWS) : 1;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] LD_ERASE   = CNT_W'(C_ERASE);
  localparam logic [CNT_W-1:0] LD_EXPOSE  = CNT_W'(C_EXPOSE);
  localparam logic [CNT_W-1:0] LD_CONVERT = CNT_W'(C_CONV);
  localparam logic [CNT_W-1:0] LD_READ    = CNT_W'(C_READ);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(NUM_ROWS - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ROW_W-1:0] row, row_n;
  logic             ramp_clear;
  logic             ramp_en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      row   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      row   <= row_n;
    end
  end

  // Down-counter is loaded on phase entry; the phase ends when it reads 1.
  always_comb begin
    state_n = state;
    cnt_n   = cnt - ONE;
    row_n   = row;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        row_n = '0;
        if (start) begin
          state_n = ST_ERASE;
          cnt_n   = LD_ERASE;
        end
      end
      ST_ERASE: begin
        if (cnt == ONE) begin
          state_n = ST_EXPOSE;
          cnt_n   = LD_EXPOSE;
        end
      end
      ST_EXPOSE: begin
        if (cnt == ONE) begin
          state_n = ST_CONVERT;
          cnt_n   = LD_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (cnt == ONE) begin
          state_n = ST_READ;
          cnt_n   = LD_READ;
          row_n   = '0;
        end
      end
      ST_READ: begin
        if (cnt == ONE) begin
          if (row == LAST_ROW) begin
            row_n = '0;
            if (cont_en) begin
              state_n = ST_ERASE;
              cnt_n   = LD_ERASE;
            end else begin
              state_n = ST_IDLE;
              cnt_n   = '0;
            end
          end else begin
            row_n = row + ROW_W'(1);
            cnt_n = LD_READ;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        row_n   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state view so they line up with state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      read       <= 1'b0;
      row_sel    <= '0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      erase      <= (state_n == ST_ERASE);
      expose     <= (state_n == ST_EXPOSE);
      convert    <= (state_n == ST_CONVERT);
      read       <= (state_n == ST_READ);
      row_sel    <= (state_n == ST_READ) ? (NUM_ROWS'(1) << row_n) : '0;
      data_valid <= (state_n == ST_READ) && (cnt_n == ONE);
      frame_done <= (state_n == ST_READ) && (cnt_n == ONE) && (row_n == LAST_ROW);
      busy       <= (state_n != ST_IDLE);
    end
  end

  // Ramp restarts from 0 on convert entry and is held at 0 elsewhere.
  assign ramp_clear = (state_n != ST_CONVERT) || (state != ST_CONVERT);
  assign ramp_en    = (state == ST_CONVERT);

  pixel_adc_ramp #(
    .ADC_W (ADC_W)
  ) u_adc_ramp (
    .clk   (clk),
    .reset (reset),
    .clear (ramp_clear),
    .en    (ramp_en),
    .code  (adc_code)
  );

endmodule

`default_nettype wire

// File: tb/tb_pixel_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pixel_frame_ctrl : default and reduced-parameter DUTs vs frame-position model
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pixel_frame_ctrl;

  localparam int FLD = 5 + 255 + 256 + 2 * 5;
  localparam int FLS = 1 + 1 + 4 + 1 * 2;

  typedef struct packed {
    logic        erase;
    logic        expose;
    logic        convert;
    logic        read;
    logic        dv;
    logic        fd;
    logic        busy;
    logic [31:0] adc;
    logic [31:0] rsel;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic cont_en = 1'b0;

  logic       d_erase, d_expose, d_convert, d_read, d_dv, d_fd, d_busy;
  logic [7:0] d_adc;
  logic [1:0] d_rsel;
  logic       s_erase, s_expose, s_convert, s_read, s_dv, s_fd, s_busy;
  logic [1:0] s_adc;
  logic [0:0] s_rsel;

  int n_vec = 0;
  int n_err = 0;
  int pd = 0;
  int ps = 0;

  always #5 clk = ~clk;

  pixel_frame_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .cont_en(cont_en),
    .erase(d_erase), .expose(d_expose), .convert(d_convert), .adc_code(d_adc),
    .read(d_read), .row_sel(d_rsel), .data_valid(d_dv), .frame_done(d_fd),
    .busy(d_busy)
  );

  pixel_frame_ctrl #(
    .C_ERASE(1), .C_EXPOSE(1), .ADC_W(2), .C_READ(2), .NUM_ROWS(1)
  ) u_small (
    .clk(clk), .reset(reset), .start(start), .cont_en(cont_en),
    .erase(s_erase), .expose(s_expose), .convert(s_convert), .adc_code(s_adc),
    .read(s_read), .row_sel(s_rsel), .data_valid(s_dv), .frame_done(s_fd),
    .busy(s_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Position p counts cycles into the frame (0 = idle, 1 = first erase cycle).
  function automatic obs_t model(input int p, input int e, input int x, input int aw,
                                 input int r, input int n);
    obs_t o;
    int a, q;
    o = '0;
    a = 1 << aw;
    if (p == 0) return o;
    o.busy = 1'b1;
    if (p <= e) o.erase = 1'b1;
    else if (p <= e + x) o.expose = 1'b1;
    else if (p <= e + x + a) begin
      o.convert = 1'b1;
      o.adc     = 32'(p - e - x - 1);
    end else begin
      q      = p - e - x - a - 1;
      o.read = 1'b1;
      o.rsel = 32'd1 << (q / r);
      o.dv   = ((q % r) == (r - 1));
      o.fd   = o.dv && ((q / r) == (n - 1));
    end
    return o;
  endfunction

  function automatic int advance(input int p, input bit rst_n, input bit st,
                                 input bit ce, input int fl);
    if (!rst_n) return 0;
    if (p == 0) return st ? 1 : 0;
    if (p == fl) return ce ? 1 : 0;
    return p + 1;
  endfunction

  task automatic compare(input string pre, input obs_t a, input obs_t e);
    logic phase_ok, rsel_ok, adc_ok;
    check({pre, "_erase"},   32'(a.erase),   32'(e.erase));
    check({pre, "_expose"},  32'(a.expose),  32'(e.expose));
    check({pre, "_convert"}, 32'(a.convert), 32'(e.convert));
    check({pre, "_read"},    32'(a.read),    32'(e.read));
    check({pre, "_dvalid"},  32'(a.dv),      32'(e.dv));
    check({pre, "_fdone"},   32'(a.fd),      32'(e.fd));
    check({pre, "_busy"},    32'(a.busy),    32'(e.busy));
    check({pre, "_adc"},     a.adc,          e.adc);
    check({pre, "_rowsel"},  a.rsel,         e.rsel);
    phase_ok = $onehot0({a.erase, a.expose, a.convert, a.read});
    rsel_ok  = a.read ? $onehot(a.rsel) : (a.rsel == 32'd0);
    adc_ok   = (a.adc == 32'd0) || a.convert;
    check({pre, "_inv_phase"},  32'(phase_ok), 32'd1);
    check({pre, "_inv_rowsel"}, 32'(rsel_ok),  32'd1);
    check({pre, "_inv_adc"},    32'(adc_ok),   32'd1);
  endtask

  task automatic cycle(input bit r, input bit s, input bit c);
    obs_t ad, as_;
    reset   = r;
    start   = s;
    cont_en = c;
    @(posedge clk);
    pd = advance(pd, r, s, c, FLD);
    ps = advance(ps, r, s, c, FLS);
    @(negedge clk);
    ad  = '{d_erase, d_expose, d_convert, d_read, d_dv, d_fd, d_busy, 32'(d_adc), 32'(d_rsel)};
    as_ = '{s_erase, s_expose, s_convert, s_read, s_dv, s_fd, s_busy, 32'(s_adc), 32'(s_rsel)};
    compare("def", ad, model(pd, 5, 255, 8, 5, 2));
    compare("sml", as_, model(ps, 1, 1, 2, 2, 1));
  endtask

  initial begin
    int done_d, done_s, nd, rise_at;
    bit prev_erase, ce;

    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);

    // Single frame: start in cycle 0 only
    done_d = -1;
    done_s = -1;
    for (int i = 0; i < 540; i++) begin
      cycle(1'b1, i == 0, 1'b0);
      if (d_fd && done_d < 0) done_d = i + 1;
      if (s_fd && done_s < 0) done_s = i + 1;
    end
    check("frame_done_cycle_default", 32'(done_d), 32'd526);
    check("frame_done_cycle_small", 32'(done_s), 32'd8);

    // Continuous mode: second frame_done without idle gap
    nd = 0;
    done_d = -1;
    for (int i = 0; i < 1060; i++) begin
      cycle(1'b1, i == 0, 1'b1);
      if (d_fd) begin
        nd++;
        if (nd == 2) done_d = i + 1;
      end
    end
    check("cont_second_done_cycle", 32'(done_d), 32'd1052);
    for (int i = 0; i < 600; i++) cycle(1'b1, 1'b0, 1'b0);

    // start held high: ignored mid-frame, re-sampled once idle
    rise_at = -1;
    prev_erase = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (d_erase && !prev_erase && i > 0 && rise_at < 0) rise_at = i + 1;
      prev_erase = d_erase;
    end
    check("held_start_rerise_cycle", 32'(rise_at), 32'd528);
    for (int i = 0; i < 600; i++) cycle(1'b1, 1'b0, 1'b0);

    // Abort with reset during convert, then a fresh full frame
    nd = 0;
    done_d = -1;
    for (int i = 0; i < 960; i++) begin
      cycle(i != 300, (i == 0) || (i == 400), 1'b0);
      if (d_fd && i < 400) nd++;
      if (d_fd && i >= 400 && done_d < 0) done_d = i + 1;
    end
    check("abort_no_frame_done", 32'(nd), 32'd0);
    check("after_abort_done_cycle", 32'(done_d), 32'd926);

    // Randomised traffic
    ce = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) == 0) ce = ~ce;
      cycle($urandom_range(0, 499) != 0, $urandom_range(0, 19) == 0, ce);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
